// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, debounces
// a detected press, reports it once, then debounces the release before resuming.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [1:0]       low_row;
  logic             row_low;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Lowest-index low row wins when several keys share the scanned column.
  always_comb begin
    if (!rows[0])      low_row = 2'd0;
    else if (!rows[1]) low_row = 2'd1;
    else if (!rows[2]) low_row = 2'd2;
    else               low_row = 2'd3;
  end

  assign row_low = ~rows[row_q];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rows == 4'hF) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = PRESS_DB;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PRESS_DB: begin
        if (row_low) begin
          if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            valid_d = 1'b1;
            code_d  = key_lut(row_q, col_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end
      HELD: begin
        // Column stays frozen, so other keys cannot be seen until release.
        if (!row_low) begin
          cnt_d   = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (row_low) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      div_q   <= '0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign cols      = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a small keypad model (SCAN_DIV=4,
// DEBOUNCE_CYCLES=8); rows can also be forced directly for bounce sequences.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] key_down;
  logic [3:0]  kp_rows;
  logic [3:0]  rows_force;
  logic        use_force;

  int total;
  int bad;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Physical keypad: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    kp_rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r*4+c] && !cols[c]) kp_rows[r] = 1'b0;
  end
  assign rows = use_force ? rows_force : kp_rows;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [3:0] code;
    logic [3:0] exp_cols;
  } vec_t;
  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int found);
    found = 0;
    for (int i = 0; i < bound && found == 0; i++) begin
      step();
      if (key_valid) found = 1;
    end
  endtask

  task automatic wait_release(input int bound, output int found);
    found = 0;
    for (int i = 0; i < bound && found == 0; i++) begin
      step();
      if (!key_held) found = 1;
    end
  endtask

  initial begin
    int found;
    int pulses;
    int pulse_at;

    vecs[0]  = '{2'd0, 2'd0, 4'h1, 4'b1110};
    vecs[1]  = '{2'd0, 2'd1, 4'h2, 4'b1101};
    vecs[2]  = '{2'd0, 2'd2, 4'h3, 4'b1011};
    vecs[3]  = '{2'd0, 2'd3, 4'hA, 4'b0111};
    vecs[4]  = '{2'd1, 2'd0, 4'h4, 4'b1110};
    vecs[5]  = '{2'd1, 2'd1, 4'h5, 4'b1101};
    vecs[6]  = '{2'd1, 2'd2, 4'h6, 4'b1011};
    vecs[7]  = '{2'd1, 2'd3, 4'hB, 4'b0111};
    vecs[8]  = '{2'd2, 2'd0, 4'h7, 4'b1110};
    vecs[9]  = '{2'd2, 2'd1, 4'h8, 4'b1101};
    vecs[10] = '{2'd2, 2'd2, 4'h9, 4'b1011};
    vecs[11] = '{2'd2, 2'd3, 4'hC, 4'b0111};
    vecs[12] = '{2'd3, 2'd0, 4'hE, 4'b1110};
    vecs[13] = '{2'd3, 2'd1, 4'h0, 4'b1101};
    vecs[14] = '{2'd3, 2'd2, 4'hF, 4'b1011};
    vecs[15] = '{2'd3, 2'd3, 4'hD, 4'b0111};

    total = 0; bad = 0;
    clk = 1'b0; reset = 1'b0;
    key_down = '0; use_force = 1'b0; rows_force = 4'hF;

    // Reset values and idle scan timing.
    do_reset();
    chk("rst_cols", cols, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    pulses = 0;
    for (int k = 1; k <= 32; k++) begin
      step();
      chk($sformatf("idle_cols_%0d", k), cols, ~(32'd1 << ((k / 4) % 4)) & 32'hF);
      if (key_valid) pulses++;
    end
    chk("idle_pulses", pulses, 0);

    // Clean press of '6': sample at cycle 12 on col2, accepted 8 cycles later.
    do_reset();
    key_down = 16'd1 << (1*4 + 2);
    pulses = 0; pulse_at = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (key_valid) begin pulses++; pulse_at = k; end
    end
    chk("k6_pulses", pulses, 1);
    chk("k6_pulse_cycle", pulse_at, 20);
    chk("k6_code", key_code, 4'h6);
    chk("k6_held", key_held, 1'b1);
    chk("k6_cols", cols, 4'b1011);
    key_down = '0;

    // Press bounce on col0: three low samples, then high.
    do_reset();
    use_force = 1'b1; rows_force = 4'hF;
    pulses = 0;
    repeat (3) step();
    rows_force = 4'b1110;
    repeat (3) begin step(); if (key_valid) pulses++; end
    rows_force = 4'hF;
    step();
    chk("bnc_cols_col1", cols, 4'b1101);
    chk("bnc_held", key_held, 1'b0);
    repeat (3) begin step(); if (key_valid) pulses++; end
    chk("bnc_cols_hold", cols, 4'b1101);
    step();
    chk("bnc_cols_col2", cols, 4'b1011);
    chk("bnc_pulses", pulses, 0);
    chk("bnc_code", key_code, 4'h0);

    // Release bounce after 'D'.
    do_reset();
    use_force = 1'b0;
    key_down = 16'd1 << (3*4 + 3);
    wait_valid(100, found);
    chk("rb_found", found, 1);
    chk("rb_code", key_code, 4'hD);
    chk("rb_cols", cols, 4'b0111);
    use_force = 1'b1; rows_force = 4'b0111; key_down = '0;
    pulses = 0;
    for (int ph = 0; ph < 4; ph++) begin
      rows_force = (ph % 2 == 0) ? 4'hF : 4'b0111;
      repeat (3) begin step(); if (key_valid) pulses++; end
      chk($sformatf("rb_held_ph%0d", ph), key_held, 1'b1);
    end
    rows_force = 4'hF;
    repeat (7) begin step(); if (key_valid) pulses++; end
    chk("rb_held_7", key_held, 1'b1);
    step();
    chk("rb_held_8", key_held, 1'b0);
    chk("rb_cols_wrap", cols, 4'b1110);
    chk("rb_pulses", pulses, 0);
    chk("rb_code_hold", key_code, 4'hD);

    // Dual press in col1 (rows=1010): row0 wins; later row2 during HELD ignored.
    do_reset();
    use_force = 1'b0;
    key_down = (16'd1 << (0*4 + 1)) | (16'd1 << (2*4 + 1));
    wait_valid(100, found);
    chk("dual_found", found, 1);
    chk("dual_code", key_code, 4'h2);
    use_force = 1'b1; rows_force = 4'b1110; key_down = '0;
    pulses = 0;
    repeat (3) begin step(); if (key_valid) pulses++; end
    rows_force = 4'b1010;
    repeat (20) begin step(); if (key_valid) pulses++; end
    chk("dual_pulses", pulses, 0);
    chk("dual_held", key_held, 1'b1);
    chk("dual_cols", cols, 4'b1101);
    chk("dual_code_hold", key_code, 4'h2);
    rows_force = 4'hF;
    wait_release(20, found);
    chk("dual_released", found, 1);
    chk("dual_cols_next", cols, 4'b1011);

    // Reset asserted while debouncing a press of '1'.
    use_force = 1'b0;
    key_down = 16'd1 << (0*4 + 0);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (cols == 4'b1110) found = 1;
    end
    chk("rm_col0_reached", found, 1);
    pulses = 0;
    repeat (6) begin step(); if (key_valid) pulses++; end
    chk("rm_no_pulse", pulses, 0);
    reset = 1'b0;
    #1;
    chk("rm_cols", cols, 4'b1110);
    chk("rm_code", key_code, 4'h0);
    chk("rm_valid", key_valid, 1'b0);
    chk("rm_held", key_held, 1'b0);
    step(); step();
    chk("rm_cols_hold", cols, 4'b1110);
    chk("rm_held_hold", key_held, 1'b0);
    reset = 1'b1;
    pulses = 0; pulse_at = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (key_valid) begin pulses++; pulse_at = k; end
    end
    chk("rm_after_pulses", pulses, 1);
    chk("rm_after_cycle", pulse_at, 12);
    chk("rm_after_code", key_code, 4'h1);
    key_down = '0;

    // Full key map.
    for (int v = 0; v < 16; v++) begin
      do_reset();
      use_force = 1'b0;
      key_down = 16'd1 << (vecs[v].r * 4 + vecs[v].c);
      wait_valid(60, found);
      chk($sformatf("map%0d_found", v), found, 1);
      chk($sformatf("map%0d_code", v), key_code, vecs[v].code);
      chk($sformatf("map%0d_cols", v), cols, vecs[v].exp_cols);
      chk($sformatf("map%0d_held", v), key_held, 1'b1);
      step();
      chk($sformatf("map%0d_pulse_end", v), key_valid, 1'b0);
      key_down = '0;
      wait_release(30, found);
      chk($sformatf("map%0d_released", v), found, 1);
      $display("key r%0d c%0d -> code %0h", vecs[v].r, vecs[v].c, key_code);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SCAN_DIV, default 1000, giving the number of clock cycles each column is driven during scanning (legal range 2 or more).
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the number of consecutive stable samples required for press or release (legal range 2 or more).
REQ-003 Port: clk  input  1  sole clock; every register updates on its rising edge.
REQ-004 Port: reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 Port: rows  input  4  keypad row lines, already synchronized, active-low; pulled up when no key is pressed.
REQ-006 Port: cols  output  4  keypad column drive, active-low; exactly one bit is low at all times.
REQ-007 Port: key_code  output  4  hex code of the last accepted key; holds its value until the next accept.
REQ-008 Port: key_valid  output  1  one-cycle pulse on acceptance of a debounced press.
REQ-009 Port: key_held  output  1  high while an accepted key has not yet completed release debounce.

Function
REQ-010 Column index col (2 bits) SHALL drive cols = ~(4'b0001 << col).
REQ-011 Key map SHALL be, by [row][col]: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = E,0,F,D.
REQ-012 The FSM SHALL have four states: SCAN, PRESS_DB, HELD and RELEASE_DB.
REQ-013 In SCAN, divider div SHALL count 0..SCAN_DIV-1, and rows SHALL be sampled only on the cycle where div == SCAN_DIV-1.
REQ-014 On that SCAN sample, if rows == 4'hF the FSM SHALL advance col by one (mod 4, 3 wraps to 0) and clear div.
REQ-015 On that SCAN sample, if any row bit is low, the FSM SHALL capture the lowest-index low row and the current col, keep col unchanged, clear the debounce counter and enter PRESS_DB.
REQ-016 In PRESS_DB, each cycle the captured row is low SHALL increment the counter; reaching DEBOUNCE_CYCLES-1 with the row low SHALL enter HELD.
REQ-017 In PRESS_DB, a high captured row on any cycle SHALL return the FSM to SCAN with col advanced and div cleared, and SHALL produce no key_valid pulse.
REQ-018 On the PRESS_DB->HELD transition cycle, key_valid SHALL be 1 and key_code SHALL update in that same cycle; key_valid SHALL be 0 on all other cycles.
REQ-019 In HELD, col SHALL stay frozen; additional rows going low SHALL be ignored (no rollover and no second pulse).
REQ-020 In HELD, a high captured row SHALL clear the counter and enter RELEASE_DB.
REQ-021 In RELEASE_DB, the counter SHALL increment while the captured row is high and SHALL clear if the row goes low again (the FSM stays in RELEASE_DB with no new pulse).
REQ-022 In RELEASE_DB, reaching DEBOUNCE_CYCLES-1 with the row high SHALL enter SCAN with col advanced.
REQ-023 key_held SHALL be 1 in HELD and RELEASE_DB and 0 otherwise.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter, and counters SHALL never wrap past their terminal value.
REQ-025 Simultaneous presses in one column SHALL resolve to the lowest row index; a press in another column SHALL be seen only when that column is scanned after release.

Reset
REQ-026 Asserting reset low at any time, including mid-debounce or in HELD, SHALL immediately force: state SCAN, col 0 (cols = 4'b1110), div 0, counter 0, key_code 4'h0, key_valid 0, key_held 0.
REQ-027 After reset deasserts, the first rows sample SHALL occur SCAN_DIV cycles later, on col 0.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-028 Idle: rows = 4'hF for 32 cycles -> cols cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid stays 0.
REQ-029 Clean press of key '6' (row1 low only while col2 is driven, held 20 cycles) -> exactly one key_valid pulse with key_code 4'h6; key_held=1; cols frozen at 4'b1011.
REQ-030 Bounce on press: row0 low on col0 for 3 cycles, then high -> no key_valid; scanning resumes at col1.
REQ-031 Release bounce: after 'D' is accepted, row3 toggles high/low every 3 cycles, then stays high 8 cycles -> no extra pulse; key_held falls after the 8th high cycle; scanning resumes at col0 (wrap from col3).
REQ-032 Dual press: rows = 4'b1010 while col1 is driven -> key_code 4'h2 (row0 wins); a later row2 press during HELD is ignored.
REQ-033 Reset mid-PRESS_DB (reset low for 2 cycles) -> all outputs at reset values immediately, with no pulse; normal scan follows.
